// File: rtl/nv_ram_fifo_pkg.sv
// Shared constants and helpers for the nv_ram_rws FIFO controller family.
// Also provides the DEPTH/AW consistency check used at elaboration.
`ifndef NV_RAM_FIFO_PKG_SV
`define NV_RAM_FIFO_PKG_SV

`define NV_RAM_FIFO_DEPTH_CHECK(depth, aw) \
    if ((depth) != (1 << (aw))) begin : g_depth_check \
        $error("nv_ram_fifo: DEPTH must equal 1<<AW"); \
    end

package nv_ram_fifo_pkg;

    localparam int unsigned OUTBUF_DEPTH = 2;

    function automatic int unsigned cnt_width(input int unsigned aw);
        return aw + 2;
    endfunction

endpackage

`endif

// File: rtl/nv_ram_fifo_outbuf.sv
// Two-entry in-order output buffer; head is presented straight from storage.
// Capture and pop may happen in the same cycle.
module nv_ram_fifo_outbuf
    import nv_ram_fifo_pkg::*;
#(
    parameter int DW = 1088
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem [OUTBUF_DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/nv_ram_rws_fifo_ctrl.sv
// Valid/ready FIFO controller around an external 1R1W RAM with registered read.
// Optional NV_RAM_FIFO_CTRL_BYPASS_EN routes pushes straight into the output buffer when idle.
module nv_ram_rws_fifo_ctrl
    import nv_ram_fifo_pkg::*;
#(
    parameter int DW    = 1088,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    output logic [AW+1:0] fifo_cnt
);

    `NV_RAM_FIFO_DEPTH_CHECK(DEPTH, AW)

    localparam int          CW      = cnt_width(AW);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   ram_cnt;
    logic          inflight;
    logic [1:0]    occ;
    logic [AW:0]   held;
    logic [2:0]    room_lim;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          ob_push;
    logic [DW-1:0] ob_data;

    always_comb begin
        rd_pvld  = (occ != '0);
        held     = ram_cnt + (AW+1)'(inflight);
        wr_prdy  = !rst && (held < DEPTH_C);
        push     = wr_pvld && wr_prdy;
        pop      = rd_pvld && rd_prdy;
        // Slots the outbuf can still accept by the time a new read returns.
        room_lim = 3'(OUTBUF_DEPTH) + {2'b0, pop};
`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
        bypass   = push && (ram_cnt == '0) && !inflight && ({1'b0, occ} < room_lim);
`else
        bypass   = 1'b0;
`endif
        ram_we   = push && !bypass;
        ram_wa   = wptr;
        ram_di   = wr_pd;
        ram_re   = !rst && (ram_cnt != '0) &&
                   (({1'b0, occ} + {2'b0, inflight}) < room_lim);
        ram_ra   = rptr;
        ob_push  = bypass || inflight;
        ob_data  = bypass ? wr_pd : ram_dout;
        fifo_cnt = {1'b0, ram_cnt} + CW'(inflight) + CW'(occ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (ram_we) wptr <= wptr + AW'(1);
            if (ram_re) rptr <= rptr + AW'(1);
            ram_cnt  <= ram_cnt + (AW+1)'(ram_we) - (AW+1)'(ram_re);
            inflight <= ram_re;
        end
    end

    nv_ram_fifo_outbuf #(
        .DW (DW)
    ) u_outbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (ob_push),
        .push_data (ob_data),
        .pop       (pop),
        .occ       (occ),
        .head      (rd_pd)
    );

endmodule

// File: tb/tb_nv_ram_rws_fifo_ctrl.sv
// Scoreboard bench for nv_ram_rws_fifo_ctrl with a behavioural RAM and queue model.
module tb_nv_ram_rws_fifo_ctrl;

    localparam int DW    = 1088;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
    localparam int LAT       = 1;
    localparam int SINGLE_WE = 0;
`else
    localparam int LAT       = 3;
    localparam int SINGLE_WE = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_pvld = 1'b0;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd = '0;
    logic          rd_pvld;
    logic          rd_prdy = 1'b0;
    logic [DW-1:0] rd_pd;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic [AW+1:0] fifo_cnt;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model [$];
    logic [DW-1:0] mem [DEPTH];

    nv_ram_rws_fifo_ctrl #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_pvld  (wr_pvld),
        .wr_prdy  (wr_prdy),
        .wr_pd    (wr_pd),
        .rd_pvld  (rd_pvld),
        .rd_prdy  (rd_prdy),
        .rd_pd    (rd_pd),
        .ram_we   (ram_we),
        .ram_wa   (ram_wa),
        .ram_di   (ram_di),
        .ram_re   (ram_re),
        .ram_ra   (ram_ra),
        .ram_dout (ram_dout),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    // External RAM: registered read, data valid the cycle after re.
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_dout <= mem[ram_ra];
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] gen();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Monitor: model bookkeeping and per-cycle checks, sampled on the falling edge.
    initial begin
        logic [DW-1:0] exp_d;
        logic          prev_re;
        logic [AW-1:0] prev_ra;
        int            exp_wa;
        int            exp_ra;
        prev_re = 1'b0;
        prev_ra = '0;
        exp_wa  = 0;
        exp_ra  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model.delete();
                prev_re = 1'b0;
                exp_wa  = 0;
                exp_ra  = 0;
            end else begin
                chk("fifo_cnt", 64'(fifo_cnt), 64'(model.size()));
                if (model.size() < DEPTH) chk("wr_prdy_open", 64'(wr_prdy), 64'd1);
                if (ram_we) begin
                    chk("ram_wa_seq", 64'(ram_wa), 64'(exp_wa));
                    exp_wa = (exp_wa + 1) % DEPTH;
                    if (prev_re) chk("wa_vs_capture", 64'(ram_wa != prev_ra), 64'd1);
                end
                if (ram_re) begin
                    chk("ram_ra_seq", 64'(ram_ra), 64'(exp_ra));
                    exp_ra = (exp_ra + 1) % DEPTH;
                end
                if (rd_pvld && rd_prdy) begin
                    checks++;
                    if (model.size() == 0) begin
                        errors++;
                        $display("FAIL pop_empty: got beat %h expected none at %0t", rd_pd[127:0], $time);
                    end else begin
                        exp_d = model.pop_front();
                        if (rd_pd !== exp_d) begin
                            errors++;
                            $display("FAIL rd_pd: got %h expected %h at %0t", rd_pd[127:0], exp_d[127:0], $time);
                        end
                    end
                end
                if (wr_pvld && wr_prdy) model.push_back(wr_pd);
                prev_re = ram_re;
                prev_ra = ram_ra;
            end
        end
    end

    initial begin
        int lat, n, guard, pops, first, last, stalls, sent;
        bit acc;

        // Reset held for three edges.
        tick();
        tick();
        @(negedge clk);
        chk("rst_rd_pvld", 64'(rd_pvld), 64'd0);
        chk("rst_wr_prdy", 64'(wr_prdy), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_re", 64'(ram_re), 64'd0);
        chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("wr_prdy_after_rst", 64'(wr_prdy), 64'd1);

        // Single beat latency.
        tick();
        wr_pvld = 1'b1;
        wr_pd   = {(DW/8){8'hA5}};
        rd_prdy = 1'b1;
        #1;
        chk("single_ram_we", 64'(ram_we), 64'(SINGLE_WE));
        tick();
        wr_pvld = 1'b0;
        lat = 1;
        while (!rd_pvld && lat < 10) begin
            tick();
            lat++;
        end
        chk("single_latency", 64'(lat), 64'(LAT));
        repeat (3) tick();

        // Fill to capacity with the consumer stalled.
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        wr_pd   = gen();
        n = 0;
        guard = 0;
        while (n < DEPTH + 2 && guard < 300) begin
            @(negedge clk);
            acc = wr_prdy;
            tick();
            if (acc) begin
                n++;
                wr_pd = gen();
            end
            guard++;
        end
        chk("fill_accepted", 64'(n), 64'(DEPTH + 2));
        @(negedge clk);
        chk("full_wr_prdy", 64'(wr_prdy), 64'd0);
        chk("full_fifo_cnt", 64'(fifo_cnt), 64'(DEPTH + 2));
        repeat (3) @(negedge clk);
        chk("full_wr_prdy_hold", 64'(wr_prdy), 64'd0);
        tick();
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        pops = 0; first = -1; last = -1; guard = 0;
        while (pops < DEPTH + 2 && guard < 300) begin
            @(negedge clk);
            if (rd_pvld && rd_prdy) begin
                if (pops == 0) first = guard;
                pops++;
                last = guard;
            end
            guard++;
        end
        chk("drain_count", 64'(pops), 64'(DEPTH + 2));
        chk("drain_span", 64'(last - first + 1), 64'(DEPTH + 2));
        tick();

        // Streaming: push and pop every cycle, pointers wrap.
        rd_prdy = 1'b1;
        wr_pvld = 1'b1;
        wr_pd   = gen();
        sent = 0; pops = 0; first = -1; last = -1; stalls = 0; guard = 0;
        while (pops < 200 && guard < 800) begin
            @(negedge clk);
            acc = wr_pvld && wr_prdy;
            if (wr_pvld && !wr_prdy) stalls++;
            if (rd_pvld && rd_prdy) begin
                if (pops == 0) first = guard;
                pops++;
                last = guard;
            end
            tick();
            if (acc) begin
                sent++;
                if (sent == 200) wr_pvld = 1'b0;
                else             wr_pd = gen();
            end
            guard++;
        end
        chk("stream_pops", 64'(pops), 64'd200);
        chk("stream_span", 64'(last - first + 1), 64'd200);
        chk("stream_stalls", 64'(stalls), 64'd0);
        chk("stream_first_pop", 64'(first), 64'(LAT));

        // Random valid/ready, 10k beats then drain.
        sent = 0; guard = 0;
        while ((sent < 10000 || model.size() > 0) && guard < 60000) begin
            wr_pvld = (sent < 10000) ? 1'($urandom_range(1)) : 1'b0;
            rd_prdy = (sent < 10000) ? 1'($urandom_range(1)) : 1'b1;
            wr_pd   = gen();
            @(negedge clk);
            acc = wr_pvld && wr_prdy;
            tick();
            if (acc) sent++;
            guard++;
        end
        chk("random_sent", 64'(sent), 64'd10000);
        chk("random_drained", 64'(model.size()), 64'd0);

        // Reset while a RAM read is in flight.
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        tick();
        wr_pvld = 1'b1;
        wr_pd   = gen();
        n = 0; guard = 0;
        while (n < 4 && guard < 50) begin
            @(negedge clk);
            acc = wr_prdy;
            tick();
            if (acc) begin
                n++;
                wr_pd = gen();
            end
            guard++;
        end
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 20) begin
            @(negedge clk);
            acc = ram_re;
            guard++;
        end
        chk("inflight_seen", 64'(acc), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_rd_pvld", 64'(rd_pvld), 64'd0);
            chk("post_rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
